// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int UART_DATA_BITS = 8;

    // Bit period in clock cycles, rounded to the nearest whole cycle.
    function automatic int uart_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: rd_data always presents the head entry.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (level == (AW + 1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // NOTE: the storage array has no reset; pointers and level alone define
    // which entries are valid, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: valid/ready byte input, FIFO, serial txd.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 25_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk_25mhz,
    input  logic                        rst,
    input  logic [UART_DATA_BITS-1:0]   in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        txd,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] level
);

    localparam int DIV   = uart_div(CLK_HZ, BAUD);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_fifo: bit period DIV must be at least 2 cycles");
    end

    uart_state_t               state;
    logic [CNT_W-1:0]          baud_cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shift;
    logic                      line_active;
    logic [UART_DATA_BITS-1:0] head;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      bit_done;
    logic                      pop;

    assign in_ready = !fifo_full;
    assign bit_done = (baud_cnt == CNT_W'(DIV - 1));
    assign pop      = ((state == IDLE) || (state == STOP && bit_done)) && !fifo_empty;

    // txd trails the state by one cycle, so line_active covers that last cycle.
    assign busy = (state != IDLE) || line_active || (level != '0);

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_25mhz),
        .rst     (rst),
        .wr_en   (in_valid && in_ready),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_data (head),
        .level   (level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            txd         <= 1'b1;
            line_active <= 1'b0;
        end else begin
            txd         <= (state == START) ? 1'b0 :
                           (state == DATA)  ? shift[0] : 1'b1;
            line_active <= (state != IDLE);

            if (state == IDLE || bit_done) baud_cnt <= '0;
            else                           baud_cnt <= baud_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (pop) begin
                        shift <= head;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'(UART_DATA_BITS - 1)) state <= STOP;
                    end
                end
                STOP: begin
                    // A waiting byte starts its frame straight after the stop bit.
                    if (bit_done) begin
                        if (pop) begin
                            shift <= head;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo at DIV=8, FIFO_DEPTH=4.
module tb_uart_tx_fifo;

    localparam int CLK_HZ     = 25_000_000;
    localparam int BAUD       = 3_125_000;
    localparam int FIFO_DEPTH = 4;
    localparam int DIV        = 8;
    localparam int FRAME      = 10 * DIV;

    logic       clk_25mhz = 1'b0;
    logic       rst       = 1'b1;
    logic [7:0] in_data   = 8'h00;
    logic       in_valid  = 1'b0;
    logic       in_ready;
    logic       txd;
    logic       busy;
    logic [2:0] level;

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic [7:0] exp_q[$];
    int         starts[$];

    uart_tx_fifo #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_25mhz (clk_25mhz),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .txd       (txd),
        .busy      (busy),
        .level     (level)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    always @(posedge clk_25mhz) begin
        cyc <= cyc + 1;
        if (!rst && in_valid && in_ready) exp_q.push_back(in_data);
    end

    // Line decoder: samples every cycle of a frame and checks it against the scoreboard.
    initial begin : monitor
        logic [9:0] bits;
        logic       stable;
        logic       aborted;
        int         fall;
        logic [7:0] exp;
        forever begin
            @(negedge clk_25mhz);
            if (rst === 1'b0 && txd === 1'b0) begin
                fall    = cyc;
                starts.push_back(fall);
                bits    = '0;
                stable  = 1'b1;
                aborted = 1'b0;
                for (int j = 0; j < FRAME; j++) begin
                    if (j != 0) @(negedge clk_25mhz);
                    if (rst !== 1'b0) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (j % DIV == 0) bits[j / DIV] = txd;
                    else if (txd !== bits[j / DIV]) stable = 1'b0;
                end
                if (!aborted) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL frame_unexpected: got data %02h at cycle %0d, expected no frame",
                                 bits[8:1], fall);
                    end else begin
                        exp = exp_q.pop_front();
                        if (bits[8:1] !== exp || bits[0] !== 1'b0 || bits[9] !== 1'b1 || stable !== 1'b1) begin
                            errors++;
                            $display("FAIL frame_data: got data %02h start %b stop %b stable %b, expected data %02h start 0 stop 1 stable 1",
                                     bits[8:1], bits[0], bits[9], stable, exp);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #(40 * 50_000);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_idle(input int max_cycles, input string name);
        int n = 0;
        do begin
            @(negedge clk_25mhz);
            n++;
        end while (busy !== 1'b0 && n < max_cycles);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, expected 0", name, busy, n);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: %0d bytes never transmitted, expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        logic quiet = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk_25mhz);
        checks++;
        if ({txd, in_ready, busy, level} !== {1'b1, 1'b1, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset_values: txd=%b in_ready=%b busy=%b level=%0d, expected 1 1 0 0",
                     txd, in_ready, busy, level);
        end
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk_25mhz);
            if (txd !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (quiet !== 1'b1) begin
            errors++;
            $display("FAIL reset_quiet: line or busy active without a push, expected idle");
        end
    endtask

    task automatic test_single();
        int n;
        int t = 0;
        @(negedge clk_25mhz);
        in_data  = 8'h55;
        in_valid = 1'b1;
        n        = cyc + 1;
        @(negedge clk_25mhz);
        in_valid = 1'b0;
        checks++;
        if (level !== 3'd1 || txd !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_edge_n: level=%0d txd=%b busy=%b, expected 1 1 1", level, txd, busy);
        end
        @(negedge clk_25mhz);
        checks++;
        if (level !== 3'd0 || txd !== 1'b1) begin
            errors++;
            $display("FAIL single_pop: level=%0d txd=%b, expected 0 1", level, txd);
        end
        @(negedge clk_25mhz);
        checks++;
        if (txd !== 1'b0) begin
            errors++;
            $display("FAIL single_fall: txd=%b at edge N+2, expected 0", txd);
        end
        while (busy !== 1'b0 && t < 200) begin
            @(negedge clk_25mhz);
            t++;
        end
        checks++;
        if (cyc !== n + 2 + FRAME) begin
            errors++;
            $display("FAIL single_busy_drop: busy low after edge %0d, expected %0d", cyc, n + 2 + FRAME);
        end
        wait_idle(10, "single");
    endtask

    task automatic test_lsb();
        @(negedge clk_25mhz);
        in_data  = 8'h01;
        in_valid = 1'b1;
        @(negedge clk_25mhz);
        in_valid = 1'b0;
        wait_idle(200, "lsb");
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes[3] = '{8'hA5, 8'h3C, 8'hFF};
        starts.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_25mhz);
            in_data  = bytes[i];
            in_valid = 1'b1;
        end
        @(negedge clk_25mhz);
        in_valid = 1'b0;
        wait_idle(400, "b2b");
        checks++;
        if (starts.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: %0d frames, expected 3", starts.size());
        end
        for (int i = 1; i < starts.size(); i++) begin
            checks++;
            if (starts[i] - starts[i-1] != FRAME) begin
                errors++;
                $display("FAIL b2b_spacing: start gap %0d cycles, expected %0d", starts[i] - starts[i-1], FRAME);
            end
        end
    endtask

    task automatic test_full();
        int   k = 0;
        int   t = 0;
        logic saw_full = 1'b0;
        logic take;
        starts.delete();
        @(negedge clk_25mhz);
        in_data  = 8'd0;
        in_valid = 1'b1;
        while (k < 8 && t < 2000) begin
            checks++;
            if (in_ready !== (level != 3'd4) || level > 3'd4) begin
                errors++;
                $display("FAIL full_ready: in_ready=%b level=%0d, expected in_ready=(level!=4) and level<=4",
                         in_ready, level);
            end
            if (in_ready === 1'b0) saw_full = 1'b1;
            take = in_ready;
            @(negedge clk_25mhz);
            t++;
            if (take) begin
                k++;
                in_data = 8'(k);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (k != 8 || saw_full !== 1'b1) begin
            errors++;
            $display("FAIL full_accept: accepted %0d saw_full=%b, expected 8 and 1", k, saw_full);
        end
        wait_idle(1200, "full");
        checks++;
        if (starts.size() != 8) begin
            errors++;
            $display("FAIL full_count: %0d frames, expected 8", starts.size());
        end
        for (int i = 1; i < starts.size(); i++) begin
            checks++;
            if (starts[i] - starts[i-1] != FRAME) begin
                errors++;
                $display("FAIL full_spacing: start gap %0d cycles, expected %0d", starts[i] - starts[i-1], FRAME);
            end
        end
    endtask

    task automatic test_simultaneous();
        int n;
        int t = 0;
        starts.delete();
        @(negedge clk_25mhz);
        in_data  = 8'h11;
        in_valid = 1'b1;
        n        = cyc + 1;
        @(negedge clk_25mhz);
        in_data  = 8'h22;
        @(negedge clk_25mhz);
        in_data  = 8'h33;
        @(negedge clk_25mhz);
        in_valid = 1'b0;
        while (cyc < n + FRAME && t < 200) begin
            @(negedge clk_25mhz);
            t++;
        end
        checks++;
        if (level !== 3'd2) begin
            errors++;
            $display("FAIL simul_before: level=%0d before the STOP->START pop, expected 2", level);
        end
        in_data  = 8'h44;
        in_valid = 1'b1;
        @(negedge clk_25mhz);
        in_valid = 1'b0;
        checks++;
        if (level !== 3'd2) begin
            errors++;
            $display("FAIL simul_level: level=%0d after push+pop, expected 2", level);
        end
        wait_idle(600, "simul");
        checks++;
        if (starts.size() != 4 || starts[1] != n + 2 + FRAME) begin
            errors++;
            $display("FAIL simul_frames: %0d frames, second start %0d, expected 4 and %0d",
                     starts.size(), (starts.size() > 1) ? starts[1] : -1, n + 2 + FRAME);
        end
    endtask

    task automatic test_reset_mid_frame();
        int   n;
        int   t     = 0;
        logic quiet = 1'b1;
        @(negedge clk_25mhz);
        in_data  = 8'h00;
        in_valid = 1'b1;
        n        = cyc + 1;
        @(negedge clk_25mhz);
        in_valid = 1'b0;
        // Data bit 3 is on the line after edges N+34 .. N+41.
        while (cyc < n + 37 && t < 100) begin
            @(negedge clk_25mhz);
            t++;
        end
        checks++;
        if (txd !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_before: txd=%b busy=%b in data bit 3, expected 0 1", txd, busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({txd, level, busy, in_ready} !== {1'b1, 3'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_async: txd=%b level=%0d busy=%b in_ready=%b, expected 1 0 0 1",
                     txd, level, busy, in_ready);
        end
        exp_q.delete();
        repeat (2) @(negedge clk_25mhz);
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk_25mhz);
            if (txd !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (quiet !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_quiet: activity after reset without a push, expected idle");
        end
        in_data  = 8'h42;
        in_valid = 1'b1;
        @(negedge clk_25mhz);
        in_valid = 1'b0;
        wait_idle(200, "rstmid");
    endtask

    initial begin
        test_reset();
        test_single();
        test_lsb();
        test_back_to_back();
        test_full();
        test_simultaneous();
        test_reset_mid_frame();
        repeat (4) @(negedge clk_25mhz);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
